// File: rtl/seq_div_12.sv
// seq_div_12: 12-bit by 6-bit unsigned restoring divider, one quotient bit per
// clock, MSB first. Division by zero finishes in one cycle with a saturated
// quotient and the low dividend bits as the remainder.
module seq_div_12 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] dividend,
    input  logic [5:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [11:0] quotient,
    output logic [5:0]  remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // dq starts as the dividend; its MSB feeds each step and quotient bits
    // shift in at the LSB, so after 12 steps it holds the full quotient.
    logic [11:0] dq;
    logic [5:0]  dvs;
    logic [6:0]  prem;
    logic [3:0]  cnt;

    logic [6:0]  step_r;
    logic        step_q;
    logic        last_step;

    // One restoring step: returns {quotient_bit, new_partial_remainder}.
    // A set bit 6 on the incoming remainder means the shifted value is at
    // least 128, which always exceeds the divisor, so it forces a subtract.
    function automatic logic [7:0] restore_step(input logic [6:0] r_in,
                                                input logic       bit_in,
                                                input logic [5:0] d);
        logic [6:0] sh;
        logic       take;
        sh   = {r_in[5:0], bit_in};
        take = r_in[6] | (sh >= {1'b0, d});
        if (take)
            restore_step = {1'b1, sh - {1'b0, d}};
        else
            restore_step = {1'b0, sh};
    endfunction

    // Combinational divide step on the current partial remainder.
    always_comb begin
        {step_q, step_r} = restore_step(prem, dq[11], dvs);
        last_step        = (cnt == 4'd11);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = (divisor == 6'd0) ? DONE : CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last_step)
                    state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq          <= 12'd0;
            dvs         <= 6'd0;
            prem        <= 7'd0;
            cnt         <= 4'd0;
            quotient    <= 12'd0;
            remainder   <= 6'd0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor != 6'd0) begin
                            dq   <= dividend;
                            dvs  <= divisor;
                            prem <= 7'd0;
                            cnt  <= 4'd0;
                        end else begin
                            quotient    <= 12'hFFF;
                            remainder   <= dividend[5:0];
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    dq   <= {dq[10:0], step_q};
                    prem <= step_r;
                    cnt  <= cnt + 4'd1;
                    if (last_step) begin
                        quotient    <= {dq[10:0], step_q};
                        remainder   <= step_r[5:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_12.sv
// Bench for seq_div_12: directed vectors with hand-computed results, plus a
// cycle-level model of the externally visible behaviour checked every cycle.
module tb_seq_div_12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [11:0] dividend = 12'd0;
    logic [5:0]  divisor = 6'd0;
    logic        busy;
    logic        done;
    logic [11:0] quotient;
    logic [5:0]  remainder;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    seq_div_12 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an accepted operation keeps the block busy for a
    // fixed number of cycles (13 normally, 1 for divide by zero), the last of
    // which is the done cycle; results are plain integer division.
    int          left = 0;
    int          pq = 0;
    int          pr = 0;
    logic [11:0] mq = 12'd0;
    logic [5:0]  mr = 6'd0;
    logic        mz = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left = 0;
            mq   = 12'd0;
            mr   = 6'd0;
            mz   = 1'b0;
        end else if (left == 0) begin
            if (start) begin
                if (divisor == 6'd0) begin
                    left = 1;
                    mq   = 12'hFFF;
                    mr   = dividend[5:0];
                    mz   = 1'b1;
                end else begin
                    left = 13;
                    pq   = int'(dividend) / int'(divisor);
                    pr   = int'(dividend) % int'(divisor);
                end
            end
        end else begin
            left--;
            if (left == 1) begin
                mq = 12'(pq);
                mr = 6'(pr);
                mz = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        #1;
        check("busy",        busy,        int'(left != 0));
        check("done",        done,        int'(left == 1));
        check("quotient",    quotient,    mq);
        check("remainder",   remainder,   mr);
        check("div_by_zero", div_by_zero, mz);
    end

    // Present operands with start for one cycle; returns in the cycle after E0.
    task automatic launch(input logic [11:0] a, input logic [5:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // n0 is the current cycle index after E0 (cycle after E_k has index k+1);
    // lat returns the index of the edge that raised done.
    task automatic wait_done(input int n0, output int lat);
        int n;
        n = n0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: no done after %0d cycles", n);
            lat = -1;
        end else begin
            lat = n - 1;
        end
    endtask

    task automatic run_op(input string name, input logic [11:0] a, input logic [5:0] b,
                          input int eq, input int er, input int ez, input int elat);
        int lat;
        launch(a, b);
        wait_done(1, lat);
        check({name, "_latency"}, lat, elat);
        check({name, "_q"}, quotient, eq);
        check({name, "_r"}, remainder, er);
        check({name, "_dbz"}, div_by_zero, ez);
    endtask

    initial begin
        int lat;
        int ndone;
        int a;
        int b;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("max", 12'd4095, 6'd63, 65, 0, 0, 12);
        run_op("d100_7", 12'd100, 6'd7, 14, 2, 0, 12);
        run_op("d5_9", 12'd5, 6'd9, 0, 5, 0, 12);
        run_op("divzero", 12'hABC, 6'd0, 12'hFFF, 6'h3C, 1, 0);
        @(negedge clk);
        #2;
        check("divzero_busy_after", busy, 0);
        check("divzero_held_q", quotient, 12'hFFF);

        // A start while busy must be ignored, operands may change freely.
        launch(12'd100, 6'd7);
        repeat (4) @(negedge clk);
        dividend = 12'd4095;
        divisor  = 6'd1;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done(6, lat);
        check("busy_start_latency", lat, 12);
        check("busy_start_q", quotient, 14);
        check("busy_start_r", remainder, 2);
        // start held through the done cycle: ignored there, taken in IDLE.
        dividend = 12'd200;
        divisor  = 6'd13;
        start    = 1'b1;
        @(negedge clk);
        #2;
        check("idle_after_done_busy", busy, 0);
        check("idle_hold_q", quotient, 14);
        @(negedge clk);
        start = 1'b0;
        wait_done(1, lat);
        check("b2b_latency", lat, 12);
        check("b2b_q", quotient, 15);
        check("b2b_r", remainder, 5);
        run_op("b2b_next", 12'd100, 6'd7, 14, 2, 0, 12);

        // Reset in the middle of a calculation.
        launch(12'd4095, 6'd63);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_q", quotient, 0);
        check("midrst_r", remainder, 0);
        check("midrst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (16) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        run_op("after_rst", 12'd200, 6'd13, 15, 5, 0, 12);

        // Exact products: quotient must recover the multiplicand.
        for (int i = 0; i < 20; i++) begin
            a = int'($urandom_range(63, 1));
            b = int'($urandom_range(63, 1));
            launch(12'(a * b), 6'(b));
            wait_done(1, lat);
            check("rand_latency", lat, 12);
            check("rand_q", quotient, a);
            check("rand_r", remainder, 0);
            check("rand_qxb", int'(quotient) * b + int'(remainder), a * b);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_div_12.md
SEQ_DIV_12 -- requirements
Module: seq_div_12

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed: 12-bit dividend, 6-bit divisor, 12-bit quotient, 6-bit remainder.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 dividend  input  12  unsigned dividend, e.g. a 6x6 product; sampled with start.
REQ-007 divisor  input  6  unsigned divisor; sampled with start.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle pulse; results valid while high and held afterwards.
REQ-010 quotient  output  12  registered unsigned quotient.
REQ-011 remainder  output  6  registered unsigned remainder.
REQ-012 div_by_zero  output  1  registered flag for the last completed operation.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-014 IDLE with start=1 and divisor!=0 at edge E0 SHALL latch both operands, clear the 7-bit partial remainder, clear the 4-bit step counter, and enter CALC.
REQ-015 IDLE with start=1 and divisor==0 at E0 SHALL enter DONE directly and register quotient=12'hFFF, remainder=dividend[5:0] and div_by_zero=1, so done is high in the cycle after E0.
REQ-016 Each CALC edge SHALL perform one restoring step, MSB first:
- r = {r[5:0], next dividend bit}
- if r >= {1'b0,divisor}: r = r - divisor and quotient bit = 1; else quotient bit = 0.
REQ-017 After the 12th step (edge E12), the block SHALL enter DONE and register quotient, remainder=r[5:0] and div_by_zero=0.
REQ-018 done SHALL be high in the cycle after E12, i.e. 12 cycles after the start-sampling edge E0.
REQ-019 DONE SHALL return to IDLE on the next edge unconditionally, so done is exactly one cycle wide.
REQ-020 Results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor.
REQ-021 The 7-bit partial remainder SHALL never overflow.
REQ-022 start SHALL be ignored in CALC and DONE; operand changes during busy SHALL have no effect.
REQ-023 A new start is accepted at the earliest in the cycle after done, back-to-back with no extra idle cycle.
REQ-024 quotient, remainder and div_by_zero SHALL change only on entry to DONE and otherwise hold their values.
REQ-025 busy SHALL be high from the cycle after E0 through the done cycle inclusive.

Reset
REQ-026 While rst_n=0, regardless of clk, the block SHALL force: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and clear the counter and partial remainder.
REQ-027 Reset asserted mid-CALC SHALL abort the operation with no done pulse.
REQ-028 The first start sampled after rst_n rises SHALL behave as from power-up.

Verification
REQ-029 dividend=4095, divisor=63, start at E0 -> done exactly 12 cycles later; quotient=65, remainder=0, div_by_zero=0.
REQ-030 dividend=100, divisor=7 -> quotient=14, remainder=2; dividend=5, divisor=9 -> quotient=0, remainder=5.
REQ-031 dividend=12'hABC, divisor=0 -> done 1 cycle after E0; quotient=12'hFFF, remainder=6'h3C, div_by_zero=1; busy high for 1 cycle.
REQ-032 Start 100/7, then assert start with 4095/1 at cycle 5 -> ignored; the result is 14 r 2; a start in the cycle after done is accepted.
REQ-033 rst_n pulsed low at cycle 6 of CALC -> all outputs 0 immediately, no done; a subsequent 200/13 yields 15 r 5.
REQ-034 Random a,b in 1..63 with dividend=a*b, divisor=b -> quotient=a, remainder=0; compare quotient against a reference a*b multiplier model.
